// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the SNN layer-chain sequencer.
// Layer indices follow the physical chain order: conv -> LIF -> maxpool -> fc.
package snn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH,
        ERROR
    } seq_state_t;

    localparam int LAYER_CONV = 0;
    localparam int LAYER_LIF  = 1;
    localparam int LAYER_MP   = 2;
    localparam int LAYER_FC   = 3;

    localparam int DEF_NUM_LAYERS = 4;
    localparam int DEF_IDX_W      = 2;
    localparam int DEF_TS_W       = 8;
    localparam int DEF_TO_W       = 20;

endpackage

// File: rtl/snn_rise_detect.sv
// Registered rising-edge detector; the previous level is captured every cycle
// regardless of what the consumer is doing with the result.
module snn_rise_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] level_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= '0;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/snn_layer_sequencer.sv
// Per-channel scheduler for the conv -> LIF -> maxpool -> fc chain: start pulses,
// done-edge tracking, inter-layer buffer hand-off, timestep loop and watchdog.
module snn_layer_sequencer
    import snn_seq_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int TS_W       = DEF_TS_W,
    parameter int TO_W       = DEF_TO_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TS_W-1:0]       num_timesteps,
    input  logic [TO_W-1:0]       timeout_cycles,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [NUM_LAYERS-2:0] buf_sel,
    output logic                  busy,
    output logic                  run_done,
    output logic [TS_W-1:0]       timestep,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  error,
    output logic [IDX_W-1:0]      err_layer
);

    localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(NUM_LAYERS - 1);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [NUM_LAYERS-1:0] done_rise;
    logic [IDX_W-1:0]      cur_layer_q;
    logic [TS_W-1:0]       timestep_q;
    logic [TS_W-1:0]       num_ts_q;
    logic [TO_W-1:0]       timeout_q;
    logic [TO_W-1:0]       wd_cnt;
    logic [TO_W-1:0]       wd_next;
    logic [NUM_LAYERS-2:0] buf_sel_q;
    logic                  error_q;
    logic [IDX_W-1:0]      err_layer_q;
    logic [TS_W:0]         ts_inc;
    logic                  cur_rise;
    logic                  is_last;
    logic                  more_ts;
    logic                  wd_hit;
    logic                  abort_hit;

    snn_rise_detect #(
        .WIDTH(NUM_LAYERS)
    ) u_done_edge (
        .clk  (clk),
        .reset(reset),
        .level(layer_done),
        .rise (done_rise)
    );

    assign cur_rise  = done_rise[cur_layer_q];
    assign is_last   = (cur_layer_q == LAST_LAYER);
    assign ts_inc    = {1'b0, timestep_q} + (TS_W + 1)'(1);
    assign more_ts   = (ts_inc < {1'b0, num_ts_q});
    assign wd_next   = wd_cnt + TO_W'(1);
    assign wd_hit    = (timeout_q != '0) && (wd_next == timeout_q);
    assign abort_hit = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A done edge on the awaited layer beats a watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        if (abort_hit) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (start) begin
                        state_next = (num_timesteps != '0) ? ISSUE : FINISH;
                    end
                end
                ISSUE:  state_next = WAIT;
                WAIT: begin
                    if (cur_rise) begin
                        state_next = (is_last && !more_ts) ? FINISH : ISSUE;
                    end else if (wd_hit) begin
                        state_next = ERROR;
                    end
                end
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        layer_start = '0;
        busy        = 1'b0;
        run_done    = 1'b0;
        case (state)
            ISSUE: begin
                layer_start[cur_layer_q] = 1'b1;
                busy                     = 1'b1;
            end
            WAIT:    busy     = 1'b1;
            FINISH:  run_done = 1'b1;
            default: ;
        endcase
    end

    // A new run starts with every buffer owned by its producer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_layer_q <= IDX_W'(LAYER_CONV);
            timestep_q  <= '0;
            num_ts_q    <= '0;
            timeout_q   <= '0;
            wd_cnt      <= '0;
            buf_sel_q   <= '0;
            error_q     <= 1'b0;
            err_layer_q <= '0;
        end else if (abort_hit) begin
            buf_sel_q <= '0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (start && (num_timesteps != '0)) begin
                        num_ts_q    <= num_timesteps;
                        timeout_q   <= timeout_cycles;
                        timestep_q  <= '0;
                        cur_layer_q <= IDX_W'(LAYER_CONV);
                        buf_sel_q   <= '0;
                        error_q     <= 1'b0;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    if (cur_layer_q == IDX_W'(LAYER_CONV)) begin
                        if (timestep_q != '0) begin
                            buf_sel_q <= '0;
                        end
                    end else begin
                        for (int k = 0; k < NUM_LAYERS - 1; k++) begin
                            if (cur_layer_q == IDX_W'(k + 1)) begin
                                buf_sel_q[k] <= 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    wd_cnt <= wd_next;
                    if (cur_rise) begin
                        if (!is_last) begin
                            cur_layer_q <= cur_layer_q + IDX_W'(1);
                        end else if (more_ts) begin
                            timestep_q  <= ts_inc[TS_W-1:0];
                            cur_layer_q <= IDX_W'(LAYER_CONV);
                        end
                    end else if (wd_hit) begin
                        error_q     <= 1'b1;
                        err_layer_q <= cur_layer_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign buf_sel   = buf_sel_q;
    assign timestep  = timestep_q;
    assign cur_layer = cur_layer_q;
    assign error     = error_q;
    assign err_layer = err_layer_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Randomized self-checking bench: engine models with chosen latencies, and an
// event-schedule reference that predicts every start pulse and completion cycle.
module tb_snn_layer_sequencer;
    import snn_seq_pkg::*;

    localparam int NL    = DEF_NUM_LAYERS;
    localparam int IDX_W = DEF_IDX_W;
    localparam int TS_W  = DEF_TS_W;
    localparam int TO_W  = DEF_TO_W;

    typedef struct {
        int cyc;
        int layer;
        int ts;
        int cur;
        int bsel;
        int busy;
        int err;
    } pulse_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [TS_W-1:0] num_timesteps = '0;
    logic [TO_W-1:0] timeout_cycles = '0;
    logic [NL-1:0]   layer_done = '0;
    logic [NL-1:0]   layer_start;
    logic [NL-2:0]   buf_sel;
    logic            busy;
    logic            run_done;
    logic [TS_W-1:0] timestep;
    logic [IDX_W-1:0] cur_layer;
    logic            error;
    logic [IDX_W-1:0] err_layer;

    int     cyc = 0;
    int     total_cnt = 0;
    int     bad_cnt = 0;
    int     dq[NL][$];
    int     eng_cnt[NL];
    bit     force_high[NL];
    bit     eng_clear = 1'b0;
    pulse_t pulses[$];
    int     done_q[$];
    pulse_t mon_p;

    snn_layer_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .num_timesteps (num_timesteps),
        .timeout_cycles(timeout_cycles),
        .layer_done    (layer_done),
        .layer_start   (layer_start),
        .buf_sel       (buf_sel),
        .busy          (busy),
        .run_done      (run_done),
        .timestep      (timestep),
        .cur_layer     (cur_layer),
        .error         (error),
        .err_layer     (err_layer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine models: a start drops done, then done rises after the queued latency;
    // an empty queue means the engine never finishes.
    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (eng_clear) begin
                eng_cnt[l]    = 0;
                layer_done[l] = 1'b0;
            end else if (force_high[l]) begin
                layer_done[l] = 1'b1;
            end else if (layer_start[l]) begin
                layer_done[l] = 1'b0;
                if (dq[l].size() > 0) eng_cnt[l] = dq[l].pop_front();
                else eng_cnt[l] = 0;
            end else if (eng_cnt[l] > 0) begin
                eng_cnt[l]--;
                if (eng_cnt[l] == 0) layer_done[l] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (layer_start != '0) begin
            mon_p.cyc   = cyc;
            mon_p.layer = -1;
            for (int l = 0; l < NL; l++) if (layer_start[l]) mon_p.layer = l;
            mon_p.ts    = int'(timestep);
            mon_p.cur   = int'(cur_layer);
            mon_p.bsel  = int'(buf_sel);
            mon_p.busy  = int'(busy);
            mon_p.err   = int'(error);
            pulses.push_back(mon_p);
            checkOutput("start_onehot", $countones(layer_start), 1);
        end
        if (run_done) done_q.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input int got, input int expv);
        total_cnt++;
        if (got !== expv) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic waitCycle(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic applyStimulus(input int nts, input int to, output int n);
        num_timesteps  = TS_W'(nts);
        timeout_cycles = TO_W'(to);
        start          = 1'b1;
        n              = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clearEngines();
        eng_clear = 1'b1;
        repeat (2) @(negedge clk);
        eng_clear = 1'b0;
        for (int l = 0; l < NL; l++) dq[l].delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_layer_start"}, int'(layer_start), 0);
        checkOutput({tag, "_buf_sel"}, int'(buf_sel), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_run_done"}, int'(run_done), 0);
        checkOutput({tag, "_timestep"}, int'(timestep), 0);
        checkOutput({tag, "_cur_layer"}, int'(cur_layer), 0);
        checkOutput({tag, "_error"}, int'(error), 0);
        checkOutput({tag, "_err_layer"}, int'(err_layer), 0);
    endtask

    // Reference schedule: each start follows the previous one by its latency + 1,
    // completion lands one cycle after the final fc done.
    task automatic runAndCheck(input int nts, input int to, input int fixed_delay, input bit inject);
        int dly[$];
        int exp_cyc[$];
        int n;
        int s;
        int d;
        int exp_done;
        int l;
        for (int k = 0; k < NL; k++) dq[k].delete();
        for (int t = 0; t < nts; t++) begin
            for (int k = 0; k < NL; k++) begin
                d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 12));
                dly.push_back(d);
                dq[k].push_back(d);
            end
        end
        pulses.delete();
        done_q.delete();
        applyStimulus(nts, to, n);
        s = n + 1;
        for (int i = 0; i < nts * NL; i++) begin
            exp_cyc.push_back(s);
            s = s + dly[i] + 1;
        end
        exp_done = s;
        if (inject) begin
            waitCycle(n + 5);
            num_timesteps = TS_W'(nts + 2);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            waitCycle(exp_done - 3);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitCycle(exp_done + 2);
        checkOutput("pulse_count", pulses.size(), nts * NL);
        for (int i = 0; i < pulses.size() && i < nts * NL; i++) begin
            l = i % NL;
            checkOutput("start_cycle", pulses[i].cyc - n, exp_cyc[i] - n);
            checkOutput("start_layer", pulses[i].layer, l);
            checkOutput("issue_timestep", pulses[i].ts, i / NL);
            checkOutput("issue_cur_layer", pulses[i].cur, l);
            checkOutput("issue_busy", pulses[i].busy, 1);
            checkOutput("issue_error", pulses[i].err, 0);
            if (i / NL > 0)
                checkOutput("issue_buf_sel", pulses[i].bsel, (l == 0) ? (1 << (NL - 1)) - 1 : (1 << (l - 1)) - 1);
        end
        checkOutput("run_done_count", done_q.size(), 1);
        if (done_q.size() > 0) checkOutput("run_done_cycle", done_q[0] - n, exp_done - n);
        checkOutput("busy_after_run", int'(busy), 0);
        checkOutput("buf_sel_final", int'(buf_sel), (1 << (NL - 1)) - 1);
        checkOutput("timestep_final", int'(timestep), nts - 1);
    endtask

    initial begin
        int n;
        int to;
        int dc;
        int lif_at;
        int err_at;
        for (int l = 0; l < NL; l++) begin
            force_high[l] = 1'b0;
            eng_cnt[l]    = 0;
        end

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single timestep, fixed latency");
        runAndCheck(1, 0, 10, 1'b0);
        $display("[TB] three timesteps");
        runAndCheck(3, 0, 10, 1'b0);
        $display("[TB] done edge coincides with watchdog limit");
        runAndCheck(2, 7, 7, 1'b0);
        $display("[TB] random runs");
        for (int r = 0; r < 5; r++) begin
            to = ($urandom_range(0, 1) == 1) ? int'($urandom_range(12, 40)) : 0;
            runAndCheck(int'($urandom_range(1, 4)), to, 0, 1'b0);
        end

        $display("[TB] watchdog on LIF");
        for (int k = 0; k < 2; k++) begin
            clearEngines();
            to = (k == 0) ? 50 : int'($urandom_range(3, 60));
            dc = int'($urandom_range(1, 3));
            dq[LAYER_CONV].push_back(dc);
            pulses.delete();
            done_q.delete();
            applyStimulus(1, to, n);
            lif_at = n + 1 + dc + 1;
            err_at = lif_at + to + 1;
            waitCycle(lif_at + 2);
            force_high[LAYER_FC] = 1'b1;
            waitCycle(err_at - 1);
            checkOutput("error_before_limit", int'(error), 0);
            checkOutput("busy_before_limit", int'(busy), 1);
            waitCycle(err_at);
            checkOutput("error_at_limit", int'(error), 1);
            checkOutput("err_layer", int'(err_layer), LAYER_LIF);
            checkOutput("busy_in_error", int'(busy), 0);
            force_high[LAYER_FC] = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            @(negedge clk);
            checkOutput("error_kept_by_abort", int'(error), 1);
            checkOutput("wd_pulse_count", pulses.size(), 2);
            checkOutput("wd_run_done_count", done_q.size(), 0);
        end
        runAndCheck(1, 0, 0, 1'b0);

        $display("[TB] abort during maxpool wait");
        clearEngines();
        dq[LAYER_CONV].push_back(10);
        dq[LAYER_LIF].push_back(10);
        dq[LAYER_MP].push_back(5);
        dq[LAYER_FC].push_back(10);
        pulses.delete();
        done_q.delete();
        applyStimulus(1, 0, n);
        waitCycle(n + 28);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_buf_sel", int'(buf_sel), 0);
        waitCycle(n + 45);
        checkOutput("abort_pulse_count", pulses.size(), 3);
        if (pulses.size() >= 3) checkOutput("abort_last_layer", pulses[2].layer, LAYER_MP);
        checkOutput("abort_run_done_count", done_q.size(), 0);

        $display("[TB] zero timesteps, then start while busy");
        pulses.delete();
        done_q.delete();
        applyStimulus(0, 0, n);
        checkOutput("zero_busy_n1", int'(busy), 0);
        @(negedge clk);
        checkOutput("zero_busy_n2", int'(busy), 0);
        waitCycle(n + 4);
        checkOutput("zero_run_done_count", done_q.size(), 1);
        if (done_q.size() > 0) checkOutput("zero_run_done_cycle", done_q[0] - n, 1);
        checkOutput("zero_pulse_count", pulses.size(), 0);
        runAndCheck(1, 0, 10, 1'b1);

        $display("[TB] reset during fc wait, stale conv done");
        clearEngines();
        for (int k = 0; k < NL; k++) dq[k].push_back(10);
        pulses.delete();
        done_q.delete();
        applyStimulus(1, 0, n);
        waitCycle(n + 38);
        reset = 1'b1;
        force_high[LAYER_CONV] = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midrun_reset");
        reset = 1'b0;
        pulses.delete();
        done_q.delete();
        waitCycle(n + 46);
        checkOutput("post_reset_pulses", pulses.size(), 0);
        checkOutput("post_reset_run_done", done_q.size(), 0);
        to = int'($urandom_range(10, 30));
        applyStimulus(2, to, n);
        err_at = n + 1 + to + 1;
        waitCycle(err_at - 1);
        checkOutput("stale_error_before", int'(error), 0);
        waitCycle(err_at);
        checkOutput("stale_error_at_limit", int'(error), 1);
        checkOutput("stale_err_layer", int'(err_layer), LAYER_CONV);
        checkOutput("stale_pulse_count", pulses.size(), 1);
        force_high[LAYER_CONV] = 1'b0;
        clearEngines();
        runAndCheck(2, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
Central scheduler for one SNN channel's layer chain (conv -> LIF -> maxpool -> fc).
- Issues one-cycle start pulses to each matrix layer in order.
- Detects rising edges of each layer's done.
- Owns the select bits that hand each inter-layer RAM from producer to consumer.
- Repeats the chain for a programmable number of timesteps, with a per-layer watchdog.
- One instance per channel, sitting beside the layer engines and their RAM muxes.

Parameters:
NUM_LAYERS, 4, number of chained layer engines (index 0 = conv, last = fc)
IDX_W, 2, width of a layer index; must satisfy 2^IDX_W >= NUM_LAYERS
TS_W, 8, timestep counter width
TO_W, 20, watchdog counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  run request; sampled only in IDLE
abort  in  1  cancel run; returns to IDLE
num_timesteps  in  TS_W  timesteps per run; latched on accepted start
timeout_cycles  in  TO_W  per-layer watchdog limit; 0 disables; latched on accepted start
layer_done  in  NUM_LAYERS  level done from each engine
layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse
buf_sel  out  NUM_LAYERS-1  bit k: 0 = layer k owns buffer k, 1 = layer k+1 owns it
busy  out  1  high from accepted start until DONE/ERROR/abort
run_done  out  1  one-cycle pulse at normal completion
timestep  out  TS_W  current timestep index, 0-based
cur_layer  out  IDX_W  layer currently issued or awaited
error  out  1  sticky watchdog flag; cleared by reset or by the next accepted start
err_layer  out  IDX_W  layer that timed out; valid while error is high

Behaviour:
Reset values:
- layer_start=0, buf_sel=0, busy=0, run_done=0, timestep=0, cur_layer=0, error=0, err_layer=0.
- FSM enters IDLE; done_prev=0.
- Reset mid-run: all outputs return to these values on the next edge; no pulses follow.

FSM states:
- IDLE
  - start=1, num_timesteps!=0: latch config, clear error, busy=1 -> ISSUE.
  - start=1, num_timesteps==0: run_done pulses next cycle, busy stays 0, no layer_start.
- ISSUE (1 cycle)
  - layer_start[cur_layer]=1.
  - Watchdog cleared.
  - If cur_layer>0, buf_sel[cur_layer-1] <= 1.
  - If cur_layer==0 and timestep>0, all buf_sel <= 0.
  - -> WAIT.
- WAIT
  - Rising edge of layer_done[cur_layer] (current high, done_prev low):
    - if not last layer: cur_layer+1 -> ISSUE;
    - else if timestep+1 < num_timesteps: timestep+1, cur_layer=0 -> ISSUE;
    - else -> FINISH.
  - Edges on non-current layers are ignored.
  - Watchdog counts cycles in WAIT. When count == timeout_cycles (nonzero): error=1, err_layer=cur_layer -> ERROR.
  - A done edge in the same cycle as the timeout wins.
- FINISH (1 cycle): run_done=1, busy=0, buf_sel holds its final value -> IDLE.
- ERROR: busy=0, no pulses; stays until reset or start. start -> same as IDLE acceptance.

Timing:
- start sampled at cycle N -> layer_start[0] high at N+1.
- Done edge sampled at M -> next layer_start at M+1.
- A done already high when its layer is issued yields no edge; the watchdog catches it.

Other rules:
- abort in any non-IDLE state: next cycle IDLE, busy=0, buf_sel=0, no run_done, error unchanged. abort has priority over a simultaneous done edge.
- start while busy is ignored.
- timestep saturation cannot occur: the counter stops at num_timesteps-1.
- done_prev is registered every cycle, independent of state.

Decomposition:
Package snn_seq_pkg:
- state enum (IDLE, ISSUE, WAIT, FINISH, ERROR);
- layer index constants LAYER_CONV=0, LAYER_LIF=1, LAYER_MP=2, LAYER_FC=3;
- default widths.

Sub-module snn_rise_detect: parameterised-width registered rising-edge detector, used for layer_done.

Test Plan:
1. num_timesteps=1, timeout=0. Each engine model raises done 10 cycles after its start.
   -> layer_start pulses at 0,1,2,3 in order, 11 cycles apart; run_done 1 cycle after fc done; busy low afterwards.
2. num_timesteps=3.
   -> 12 layer_start pulses; timestep steps 0,1,2; buf_sel goes 001,011,111, then 000 at each conv reissue; one run_done.
3. timeout=50, LIF model never asserts done.
   -> error=1, err_layer=1, exactly 50 WAIT cycles after LIF start; busy=0; no mp start; next start clears error.
4. abort 5 cycles into the maxpool WAIT, with the mp done edge in the same cycle.
   -> IDLE next cycle; no fc start; buf_sel=000; no run_done.
5. start with num_timesteps=0.
   -> run_done the next cycle; no layer_start; busy never high.
   Then start pulsed while busy in a normal run -> ignored, no extra pulses.
6. reset asserted during the fc WAIT, and a stale-high conv done at restart.
   -> all outputs reset next edge. On restart, conv times out at the programmed limit, with no spurious advance.
